// File: rtl/tetris_key_tick_gen.sv
// Push-button debouncer, gravity tick and one-command-per-cycle arbiter for the falling piece.
// Optional auto-repeat of left/right while held: define TETRIS_AUTO_REPEAT_EN.
module tetris_key_tick_gen #(
    parameter int unsigned DEBOUNCE_CYC     = 250000,
    parameter int unsigned FALL_CYC         = 25000000,
    parameter int unsigned FALL_STEP        = 1500000,
    parameter int unsigned FALL_MIN         = 2500000,
    parameter int unsigned SOFT_SHIFT       = 3,
    parameter int unsigned REPEAT_DELAY_CYC = 12500000,
    parameter int unsigned REPEAT_RATE_CYC  = 4000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Starting,
    input  logic       UpdateEnable,
    input  logic [3:0] Level,
    input  logic       BtnLeft_n,
    input  logic       BtnRight_n,
    input  logic       BtnChange_n,
    input  logic       BtnDown_n,
    output logic       KeyLeft,
    output logic       KeyRight,
    output logic       KeyChange,
    output logic       TimeUp,
    output logic [3:0] Pressed
);

    localparam int unsigned DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    // Bit order everywhere: {down, change, right, left}; pending/output order: {gravity, change, right, left}
    logic [3:0]            btn_raw_s;
    logic [3:0]            sync1_q, sync2_q;
    logic [3:0]            btn_s;
    logic [3:0]            deb_q, deb_d;
    logic [3:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [2:0]            press_s;
    logic [1:0]            rep_s;
    logic [31:0]           reduce_s, base_period_s, soft_period_s, period_s;
    logic [31:0]           grav_cnt_q, grav_cnt_d;
    logic                  grav_fire_s;
    logic [3:0]            ev_s;
    logic [3:0]            pend_q, pend_d;
    logic [3:0]            grant_s;
    logic [3:0]            out_q, out_d;
    logic                  run_s;

    assign btn_raw_s = {BtnDown_n, BtnChange_n, BtnRight_n, BtnLeft_n};
    assign btn_s     = ~sync2_q;
    assign run_s     = Starting & ~UpdateEnable;

    // Debounce: a level change is accepted only after DEBOUNCE_CYC consecutive differing samples
    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (btn_s[i] == deb_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                deb_d[i]    = btn_s[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    assign press_s = deb_d[2:0] & ~deb_q[2:0];

`ifdef TETRIS_AUTO_REPEAT_EN
    localparam int unsigned RP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int unsigned RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

    logic [1:0][RP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [1:0]           rep_phase_q, rep_phase_d;
    logic [RP_W-1:0]      rep_limit_s;

    // Auto-repeat: first re-fire after the delay, then at the repeat rate while still held
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
        rep_s       = 2'b00;
        rep_limit_s = '0;
        for (int i = 0; i < 2; i++) begin
            if (rep_phase_q[i]) begin
                rep_limit_s = RP_W'(REPEAT_RATE_CYC - 1);
            end else begin
                rep_limit_s = RP_W'(REPEAT_DELAY_CYC - 1);
            end
            if (!run_s || !deb_q[i]) begin
                rep_cnt_d[i]   = '0;
                rep_phase_d[i] = 1'b0;
            end else if (rep_cnt_q[i] == rep_limit_s) begin
                rep_s[i]       = 1'b1;
                rep_cnt_d[i]   = '0;
                rep_phase_d[i] = 1'b1;
            end else begin
                rep_cnt_d[i] = rep_cnt_q[i] + RP_W'(1);
            end
        end
    end

    // Repeat counter state
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 2'b00;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
        end
    end
`else
    // Repeat timing is only meaningful with auto-repeat; tie it off so the parameters stay referenced
    localparam bit REP_CFG_ZERO = (REPEAT_DELAY_CYC == 0) && (REPEAT_RATE_CYC == 0);
    assign rep_s = {2{REP_CFG_ZERO & 1'b0}};
`endif

    // Gravity period from level, floored, then shortened while soft drop is held
    always_comb begin
        reduce_s      = 32'(Level) * 32'(FALL_STEP);
        base_period_s = 32'(FALL_MIN);
        soft_period_s = 32'd0;
        period_s      = 32'd1;
        if (reduce_s + 32'(FALL_MIN) >= 32'(FALL_CYC)) begin
            base_period_s = 32'(FALL_MIN);
        end else begin
            base_period_s = 32'(FALL_CYC) - reduce_s;
        end
        soft_period_s = base_period_s >> SOFT_SHIFT;
        if (deb_q[3]) begin
            if (soft_period_s == 32'd0) begin
                period_s = 32'd1;
            end else begin
                period_s = soft_period_s;
            end
        end else begin
            period_s = base_period_s;
        end
    end

    // ">=" so a period that shrinks below the running count fires at once
    assign grav_fire_s = (grav_cnt_q >= (period_s - 32'd1));
    assign ev_s        = {grav_fire_s, press_s[2], press_s[1] | rep_s[1], press_s[0] | rep_s[0]};

    // Arbiter: gravity > left > right > change; newly arriving events outrank this cycle's clear
    always_comb begin
        grant_s    = 4'b0000;
        pend_d     = 4'b0000;
        out_d      = 4'b0000;
        grav_cnt_d = 32'd0;
        if (pend_q[3]) begin
            grant_s = 4'b1000;
        end else if (pend_q[0]) begin
            grant_s = 4'b0001;
        end else if (pend_q[1]) begin
            grant_s = 4'b0010;
        end else if (pend_q[2]) begin
            grant_s = 4'b0100;
        end else begin
            grant_s = 4'b0000;
        end
        if (run_s) begin
            pend_d = (pend_q & ~grant_s) | ev_s;
            out_d  = grant_s;
            if (grav_fire_s) begin
                grav_cnt_d = 32'd0;
            end else begin
                grav_cnt_d = grav_cnt_q + 32'd1;
            end
        end else begin
            pend_d     = 4'b0000;
            out_d      = 4'b0000;
            grav_cnt_d = 32'd0;
        end
    end

    // Main state: synchronisers, debouncers, gravity counter, pending flags, output pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 4'hF;
            sync2_q    <= 4'hF;
            deb_q      <= 4'h0;
            db_cnt_q   <= '0;
            grav_cnt_q <= 32'd0;
            pend_q     <= 4'h0;
            out_q      <= 4'h0;
        end else begin
            sync1_q    <= btn_raw_s;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            db_cnt_q   <= db_cnt_d;
            grav_cnt_q <= grav_cnt_d;
            pend_q     <= pend_d;
            out_q      <= out_d;
        end
    end

    assign KeyLeft   = out_q[0];
    assign KeyRight  = out_q[1];
    assign KeyChange = out_q[2];
    assign TimeUp    = out_q[3];
    assign Pressed   = deb_q;

endmodule

// File: tb/tb_tetris_key_tick_gen.sv
// Scoreboard bench: directed stimulus pushes hand-computed pulse cycles; a monitor pops and compares.
module tb_tetris_key_tick_gen;

    localparam logic [3:0] L = 4'b0001;
    localparam logic [3:0] R = 4'b0010;
    localparam logic [3:0] C = 4'b0100;
    localparam logic [3:0] T = 4'b1000;

    logic       clk = 1'b0;
    logic       rst, Starting, UpdateEnable;
    logic [3:0] Level;
    logic       BtnLeft_n, BtnRight_n, BtnChange_n, BtnDown_n;
    logic       KeyLeft, KeyRight, KeyChange, TimeUp;
    logic [3:0] Pressed;

    typedef struct {
        int         at_cyc;
        logic [3:0] code;
    } exp_t;

    exp_t exp_q[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    int   r;

    tetris_key_tick_gen #(
        .DEBOUNCE_CYC(4), .FALL_CYC(20), .FALL_STEP(2), .FALL_MIN(6),
        .SOFT_SHIFT(2), .REPEAT_DELAY_CYC(10), .REPEAT_RATE_CYC(3)
    ) dut (
        .clk(clk), .rst(rst), .Starting(Starting), .UpdateEnable(UpdateEnable),
        .Level(Level), .BtnLeft_n(BtnLeft_n), .BtnRight_n(BtnRight_n),
        .BtnChange_n(BtnChange_n), .BtnDown_n(BtnDown_n),
        .KeyLeft(KeyLeft), .KeyRight(KeyRight), .KeyChange(KeyChange),
        .TimeUp(TimeUp), .Pressed(Pressed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic expect_pulse(input int c, input logic [3:0] code);
        exp_q.push_back('{at_cyc: c, code: code});
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic restart(output int ref_cyc);
        UpdateEnable = 1'b1;
        @(negedge clk);
        UpdateEnable = 1'b0;
        ref_cyc = cyc;
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation in cycle and kind
    always @(negedge clk) begin : monitor
        logic [3:0] obs;
        exp_t       e;
        obs = {TimeUp, KeyChange, KeyRight, KeyLeft};
        while (exp_q.size() > 0 && exp_q[0].at_cyc < cyc) begin
            e = exp_q.pop_front();
            n_total++;
            $display("FAIL missing_pulse: got none, expected %b at cycle %0d", e.code, e.at_cyc);
        end
        if (obs != 4'b0000) begin
            if (exp_q.size() == 0 || exp_q[0].at_cyc > cyc) begin
                n_total++;
                $display("FAIL unexpected_pulse: got %b at cycle %0d, expected none", obs, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {28'd0, obs}, {28'd0, e.code});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; Starting = 1'b0; UpdateEnable = 1'b0; Level = 4'd0;
        BtnLeft_n = 1'b1; BtnRight_n = 1'b1; BtnChange_n = 1'b1; BtnDown_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {28'd0, TimeUp, KeyChange, KeyRight, KeyLeft}, 32'd0);
        check("reset_pressed", {28'd0, Pressed}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Free-running gravity at level 0
        r = cyc;
        Starting = 1'b1;
        expect_pulse(r + 21, T); expect_pulse(r + 41, T); expect_pulse(r + 61, T);
        wait_until(r + 62);

        // Left: 2-cycle glitch ignored, then a clean held press
        restart(r);
        expect_pulse(r + 15, L);
        expect_pulse(r + 21, T);
`ifdef TETRIS_AUTO_REPEAT_EN
        expect_pulse(r + 25, L); expect_pulse(r + 28, L);
        expect_pulse(r + 31, L); expect_pulse(r + 34, L);
`endif
        expect_pulse(r + 41, T);
        wait_until(r + 1);  BtnLeft_n = 1'b0;
        wait_until(r + 3);  BtnLeft_n = 1'b1;
        wait_until(r + 8);  BtnLeft_n = 1'b0;
        wait_until(r + 20); check("pressed_left", {28'd0, Pressed}, 32'h1);
        wait_until(r + 29); BtnLeft_n = 1'b1;
        wait_until(r + 40); check("pressed_left_released", {28'd0, Pressed}, 32'h0);
        wait_until(r + 42);

        // Right and change accepted on the same cycle the gravity count expires
        restart(r);
        expect_pulse(r + 21, T); expect_pulse(r + 22, R); expect_pulse(r + 23, C);
        expect_pulse(r + 41, T);
        wait_until(r + 14); BtnRight_n = 1'b0; BtnChange_n = 1'b0;
        wait_until(r + 22); BtnRight_n = 1'b1; BtnChange_n = 1'b1;
        wait_until(r + 24); check("pressed_right_change", {28'd0, Pressed}, 32'h6);
        wait_until(r + 42);

        // Level 8 period 6, soft drop period 1, then level 0 soft drop period 5
        Level = 4'd8;
        restart(r);
        expect_pulse(r + 7, T);  expect_pulse(r + 13, T); expect_pulse(r + 19, T);
        expect_pulse(r + 25, T); expect_pulse(r + 28, T); expect_pulse(r + 29, T);
        expect_pulse(r + 30, T); expect_pulse(r + 31, T); expect_pulse(r + 36, T);
        expect_pulse(r + 41, T); expect_pulse(r + 46, T); expect_pulse(r + 51, T);
        wait_until(r + 20); BtnDown_n = 1'b0;
        wait_until(r + 30); Level = 4'd0;
        wait_until(r + 40); check("pressed_down", {28'd0, Pressed}, 32'h8);
        wait_until(r + 47); BtnDown_n = 1'b1;
        wait_until(r + 52);

        // UpdateEnable discards a pending left; Starting=0 freezes; mid-run reset drops a pulse
        restart(r);
        expect_pulse(r + 30, T);
        expect_pulse(r + 71, T);
        expect_pulse(r + 98, L);
        expect_pulse(r + 112, T);
        wait_until(r + 2);  BtnLeft_n = 1'b0;
        wait_until(r + 8);  UpdateEnable = 1'b1;
        wait_until(r + 9);  UpdateEnable = 1'b0;
        wait_until(r + 12); BtnLeft_n = 1'b1;
        wait_until(r + 31); Starting = 1'b0;
        wait_until(r + 32); BtnChange_n = 1'b0;
        wait_until(r + 40); check("pressed_idle_change", {28'd0, Pressed}, 32'h4);
        wait_until(r + 45); BtnChange_n = 1'b1;
        wait_until(r + 50); Starting = 1'b1;
        wait_until(r + 85); BtnLeft_n = 1'b0;
        wait_until(r + 90); rst = 1'b1;
        wait_until(r + 91); rst = 1'b0;
        check("midrun_reset_pressed", {28'd0, Pressed}, 32'h0);
        check("midrun_reset_outputs", {28'd0, TimeUp, KeyChange, KeyRight, KeyLeft}, 32'd0);
        wait_until(r + 100); BtnLeft_n = 1'b1;
        wait_until(r + 115);
        @(negedge clk);

        while (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL missing_pulse_end: got none, expected %b at cycle %0d",
                     exp_q[0].code, exp_q[0].at_cyc);
            void'(exp_q.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tetris_key_tick_gen.md
Name: tetris_key_tick_gen

Overview:
- Generates the single-cycle move/rotate/fall command pulses consumed by the falling-piece move/rotate logic: KeyLeft, KeyRight, KeyChange and TimeUp.
- Takes raw board push-buttons and produces the gravity tick.
- Guarantees at most one command pulse per cycle, in the priority order the consumer evaluates: TimeUp > Left > Right > Change.
- Sits between the board I/O pins and the move/rotate block; driven by the game-control Starting and UpdateEnable signals.

Parameters:
DEBOUNCE_CYC, 250000, consecutive stable cycles required to accept a button level change
FALL_CYC, 25000000, gravity period at Level 0, in cycles
FALL_STEP, 1500000, period reduction per Level increment
FALL_MIN, 2500000, floor on the gravity period
SOFT_SHIFT, 3, right-shift applied to the period while BtnDown is held
REPEAT_DELAY_CYC, 12500000, hold time before the first auto-repeat (optional feature only)
REPEAT_RATE_CYC, 4000000, interval between auto-repeats (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
Starting  in  1  game running; 0 = idle
UpdateEnable  in  1  new-piece load cycle from game control
Level  in  4  speed level, 0..15
BtnLeft_n  in  1  raw button, active-low, asynchronous
BtnRight_n  in  1  raw button, active-low, asynchronous
BtnChange_n  in  1  raw button, active-low, asynchronous
BtnDown_n  in  1  raw soft-drop button, active-low, asynchronous
KeyLeft  out  1  move-left pulse
KeyRight  out  1  move-right pulse
KeyChange  out  1  rotate pulse
TimeUp  out  1  gravity pulse
Pressed  out  4  debounced levels {down, change, right, left}, active-high

Behaviour:
- Reset: rst sampled only on rising edge of clk.
  - All outputs 0.
  - Synchronisers hold the released value (1).
  - Debounced levels 0; all counters 0; pending flags 0.
- Input path: 2-flop synchroniser per button, then inverted to active-high.
  - Per-button debounce counter clears whenever the synchronised value equals the debounced level.
  - Otherwise it increments; on reaching DEBOUNCE_CYC-1, the debounced level takes the new value and the counter clears.
  - Latency from pin edge to Pressed: 2 + DEBOUNCE_CYC cycles.
- Press event: 0->1 transition of the debounced level for left, right or change. Sets that button's pending flag.
  - One-deep per button: a repeat event while pending is absorbed.
  - Release events generate nothing.
- Gravity:
  - Period P = max(FALL_CYC - Level*FALL_STEP, FALL_MIN).
  - While debounced down is held, P >> SOFT_SHIFT, minimum 1.
  - Counter runs 0..P-1; at a count >= P-1 it sets the gravity pending flag and wraps to 0.
  - A mid-count period decrease below the current count fires on the next cycle, not after a 5-bit/32-bit wrap.
  - Counter width: 32 bits.
- Output arbiter, registered:
  - Each cycle, emits exactly one pulse for the highest-priority pending flag (gravity, left, right, change) and clears that flag only.
  - Lower-priority flags wait; one command per cycle max. Outputs are mutually exclusive.
  - Pulse appears the cycle after the flag is set.
- Starting = 0: outputs 0, gravity counter held at 0, pending flags cleared. Debouncers keep running so Pressed stays valid.
- UpdateEnable = 1: outputs 0 that cycle, all pending flags cleared, gravity counter reloaded to 0. Events detected in that same cycle are discarded.
- rst asserted mid-operation returns everything to reset values on the next edge. Any pulse in flight is dropped.

Optional Feature:
- Macro: TETRIS_AUTO_REPEAT_EN.
- Defined: left/right held debounced-pressed for REPEAT_DELAY_CYC cycles sets the pending flag again, then every REPEAT_RATE_CYC cycles while held.
  - The repeat counter clears on release, on UpdateEnable, and on Starting = 0.
  - Left and right have independent counters.
- Not defined: one pulse per press only; the repeat counters are not instantiated.

Test Plan:
(Bench parameters: DEBOUNCE_CYC=4, FALL_CYC=20, FALL_STEP=2, FALL_MIN=6, SOFT_SHIFT=2, REPEAT_DELAY_CYC=10, REPEAT_RATE_CYC=3.)
- Reset then Starting=1, Level=0, no buttons -> TimeUp high for 1 cycle every 20 cycles; first TimeUp 21 cycles after Starting rises; no other outputs.
- BtnLeft_n low with a 2-cycle glitch, then low and held -> glitch ignored; exactly one KeyLeft at cycle 2+4+1 after the stable edge; none while held, none on release.
- BtnRight_n and BtnChange_n accepted in the same cycle the gravity count expires -> TimeUp, KeyRight, KeyChange on three consecutive cycles in that order.
- Level=8 -> period max(20-16, 6) = 6; then BtnDown_n held -> period 6>>2 = 1, TimeUp every cycle; Level=0 with down held -> period 5.
- Left press pending while UpdateEnable=1 -> no pulse that cycle or after; gravity restarts, next TimeUp 20 cycles later. Starting=0 -> all outputs 0.
- With TETRIS_AUTO_REPEAT_EN, Left held 20 cycles after debounce -> KeyLeft at press, then at +10, +13, +16, +19; without the macro -> single KeyLeft.
